fetch_ctrl: RTL and testbench



---
 rtl/rv32_fetch_pkg.sv | 14 +
 rtl/fetch_wait_ctr.sv | 33 +++
 rtl/fetch_ctrl.sv | 121 ++++++++++++
 tb/tb_fetch_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_fetch_pkg.sv
// Shared types and constants for the rv32 instruction-fetch sequencer.
package rv32_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP  = 32'd4;

endpackage

// File: rtl/fetch_wait_ctr.sv
// Saturating wait counter for outstanding fetch requests; expire flags the
// increment that reaches LIMIT (never asserted when LIMIT is 0).
module fetch_wait_ctr #(
  parameter  int LIMIT = 15,
  localparam int W     = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         expire
);

  localparam logic [W-1:0] SAT = (LIMIT > 0) ? W'(LIMIT) : '0;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != SAT)) begin
      cnt <= cnt + W'(1);
    end
  end

  if (LIMIT > 0) begin : g_timeout
    assign expire = inc && !clr && (cnt == W'(LIMIT - 1));
  end else begin : g_no_timeout
    assign expire = 1'b0;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC, memory handshake, instruction register and
// redirect handling. Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects.
module fetch_ctrl
  import rv32_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        fetch_err,
  output logic        misalign_err
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  fetch_state_t  state, state_nxt;
  logic [31:0]   pc;
  logic [31:0]   target_eff;
  logic          redir_bad;
  logic          ack_take;
  logic          wait_clr, wait_inc, wait_expire;
  logic [CW-1:0] wait_cnt;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q;

  assign target_eff   = redirect_target;
  assign redir_bad    = |redirect_target[1:0];
  assign misalign_err = misalign_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      misalign_q <= 1'b0;
    end else if (redirect_valid) begin
      misalign_q <= redir_bad;
    end
  end
`else
  assign target_eff   = redirect_target & ~32'h0000_0003;
  assign redir_bad    = 1'b0;
  assign misalign_err = 1'b0;
`endif

  assign mem_addr = pc;
  assign ack_take = (state == REQ) && mem_ack && !redirect_valid;
  // Counting restarts on every entry to REQ and on any redirect.
  assign wait_clr = (state != REQ) || redirect_valid;
  assign wait_inc = (state == REQ) && !mem_ack && !redirect_valid;

  fetch_wait_ctr #(.LIMIT(TIMEOUT)) u_wait_ctr (
    .clk    (clk),
    .n_rst  (n_rst),
    .clr    (wait_clr),
    .inc    (wait_inc),
    .cnt    (wait_cnt),
    .expire (wait_expire)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Redirect always lands in IDLE for one cycle so mem_req drops and the
  // outstanding memory request is cancelled before fetching the target.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (en) state_nxt = REQ;
      REQ: begin
        if (mem_ack)          state_nxt = HOLD;
        else if (wait_expire) state_nxt = ERR;
      end
      HOLD: if (inst_ready) state_nxt = en ? REQ : IDLE;
      ERR:  state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
    if (redirect_valid) state_nxt = redir_bad ? ERR : IDLE;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pc         <= RESET_PC;
      inst_out   <= INST_NOP;
      inst_pc    <= 32'h0;
      inst_valid <= 1'b0;
      mem_req    <= 1'b0;
      fetch_err  <= 1'b0;
    end else begin
      mem_req    <= (state_nxt == REQ);
      inst_valid <= (state_nxt == HOLD);
      if (redirect_valid) begin
        pc        <= target_eff;
        fetch_err <= 1'b0;
      end else begin
        if (ack_take) begin
          inst_out <= mem_rdata;
          inst_pc  <= pc;
          pc       <= pc + PC_STEP;
        end
        if (wait_expire) fetch_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl (RESET_PC=0x100, TIMEOUT=15).
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        en;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        fetch_err;
  logic        misalign_err;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] WORD = 32'h00A0_0093;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(32'h0000_0100), .TIMEOUT(15)) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .en              (en),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata),
    .inst_out        (inst_out),
    .inst_pc         (inst_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .fetch_err       (fetch_err),
    .misalign_err    (misalign_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL %s mem_req got %b want 0", tag, mem_req); end
    n_tests++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL %s mem_addr got %h want 00000100", tag, mem_addr); end
    n_tests++; if (inst_out !== 32'h13) begin n_fail++; $display("FAIL %s inst_out got %h want 00000013", tag, inst_out); end
    n_tests++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL %s inst_pc got %h want 0", tag, inst_pc); end
    n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL %s inst_valid got %b want 0", tag, inst_valid); end
    n_tests++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL %s fetch_err got %b want 0", tag, fetch_err); end
    n_tests++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL %s misalign_err got %b want 0", tag, misalign_err); end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; en = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    mem_ack = 1'b0; mem_rdata = WORD; inst_ready = 1'b1;
    repeat (3) tick();
    check_reset_values("reset");
    n_rst = 1'b1;
    tick();
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL idle_en0 mem_req got %b want 0", mem_req); end
  endtask

  // Zero-wait memory, always-ready decoder: one instruction every 2 cycles.
  task automatic test_cadence();
    logic exp_v;
    logic [31:0] exp_pc;
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_v  = (i % 2 == 1);
      exp_pc = 32'h100 + 32'(4 * (i / 2));
      n_tests++; if (inst_valid !== exp_v) begin n_fail++; $display("FAIL cadence_valid[%0d] got %b want %b", i, inst_valid, exp_v); end
      n_tests++; if (mem_req !== !exp_v) begin n_fail++; $display("FAIL cadence_req[%0d] got %b want %b", i, mem_req, !exp_v); end
      if (exp_v) begin
        n_tests++; if (inst_pc !== exp_pc) begin n_fail++; $display("FAIL cadence_pc[%0d] got %h want %h", i, inst_pc, exp_pc); end
        n_tests++; if (inst_out !== WORD) begin n_fail++; $display("FAIL cadence_inst[%0d] got %h want %h", i, inst_out, WORD); end
      end else begin
        n_tests++; if (mem_addr !== exp_pc) begin n_fail++; $display("FAIL cadence_addr[%0d] got %h want %h", i, mem_addr, exp_pc); end
      end
      mem_ack = mem_req;
    end
    mem_ack = 1'b0;
  endtask

  // Starts in HOLD with inst_pc=0x108.
  task automatic test_stall();
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h108 || inst_out !== WORD) begin
        n_fail++; $display("FAIL stall_hold[%0d] got v=%b pc=%h inst=%h want v=1 pc=00000108 inst=%h", i, inst_valid, inst_pc, inst_out, WORD);
      end
      n_tests++; if (mem_req !== 1'b0 || mem_addr !== 32'h10C) begin
        n_fail++; $display("FAIL stall_req[%0d] got req=%b addr=%h want req=0 addr=0000010c", i, mem_req, mem_addr);
      end
    end
    inst_ready = 1'b1;
    tick();
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h10C || inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_release got req=%b addr=%h v=%b want req=1 addr=0000010c v=0", mem_req, mem_addr, inst_valid);
    end
  endtask

  // Starts in REQ at 0x10C.
  task automatic test_wait_and_timeout();
    repeat (3) tick();
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h10C) begin
      n_fail++; $display("FAIL wait3_stable got req=%b addr=%h want req=1 addr=0000010c", mem_req, mem_addr);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    n_tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h10C || fetch_err !== 1'b0) begin
      n_fail++; $display("FAIL wait3_ack got v=%b pc=%h err=%b want v=1 pc=0000010c err=0", inst_valid, inst_pc, fetch_err);
    end
    tick();
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h110) begin
      n_fail++; $display("FAIL timeout_start got req=%b addr=%h want req=1 addr=00000110", mem_req, mem_addr);
    end
    for (int i = 1; i <= 14; i++) begin
      tick();
      n_tests++; if (mem_req !== 1'b1 || fetch_err !== 1'b0) begin
        n_fail++; $display("FAIL timeout_early[%0d] got req=%b err=%b want req=1 err=0", i, mem_req, fetch_err);
      end
    end
    tick();
    n_tests++; if (fetch_err !== 1'b1 || mem_req !== 1'b0 || inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL timeout_hit got err=%b req=%b v=%b want err=1 req=0 v=0", fetch_err, mem_req, inst_valid);
    end
    mem_ack = 1'b1;
    repeat (3) tick();
    mem_ack = 1'b0;
    n_tests++; if (fetch_err !== 1'b1 || mem_req !== 1'b0 || inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL err_sticky got err=%b req=%b v=%b want err=1 req=0 v=0", fetch_err, mem_req, inst_valid);
    end
  endtask

  // Starts in ERR; redirect out, then collide a redirect with an ack.
  task automatic test_redirect_with_ack();
    redirect_valid = 1'b1; redirect_target = 32'h100;
    tick();
    redirect_valid = 1'b0;
    n_tests++; if (fetch_err !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'h100) begin
      n_fail++; $display("FAIL redir_from_err got err=%b req=%b addr=%h want err=0 req=0 addr=00000100", fetch_err, mem_req, mem_addr);
    end
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    n_tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100) begin
      n_fail++; $display("FAIL redir_refetch got v=%b pc=%h want v=1 pc=00000100", inst_valid, inst_pc);
    end
    tick();
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h104) begin
      n_fail++; $display("FAIL redir_req104 got req=%b addr=%h want req=1 addr=00000104", mem_req, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    redirect_valid = 1'b1; redirect_target = 32'h200;
    tick();
    mem_ack = 1'b0; mem_rdata = WORD; redirect_valid = 1'b0;
    n_tests++; if (mem_req !== 1'b0 || inst_valid !== 1'b0 || mem_addr !== 32'h200) begin
      n_fail++; $display("FAIL redir_gap got req=%b v=%b addr=%h want req=0 v=0 addr=00000200", mem_req, inst_valid, mem_addr);
    end
    n_tests++; if (inst_out !== WORD || inst_pc !== 32'h100) begin
      n_fail++; $display("FAIL redir_discard got inst=%h pc=%h want inst=%h pc=00000100", inst_out, inst_pc, WORD);
    end
    tick();
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin
      n_fail++; $display("FAIL redir_target got req=%b addr=%h want req=1 addr=00000200", mem_req, mem_addr);
    end
  endtask

  // Starts in REQ at 0x200.
  task automatic test_misalign();
    redirect_valid = 1'b1; redirect_target = 32'h202;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    n_tests++; if (misalign_err !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL misalign_set got merr=%b req=%b want merr=1 req=0", misalign_err, mem_req);
    end
    tick();
    n_tests++; if (misalign_err !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL misalign_hold got merr=%b req=%b want merr=1 req=0", misalign_err, mem_req);
    end
`else
    n_tests++; if (misalign_err !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'h200) begin
      n_fail++; $display("FAIL misalign_off_gap got merr=%b req=%b addr=%h want merr=0 req=0 addr=00000200", misalign_err, mem_req, mem_addr);
    end
    tick();
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin
      n_fail++; $display("FAIL misalign_off_fetch got req=%b addr=%h want req=1 addr=00000200", mem_req, mem_addr);
    end
`endif
    redirect_valid = 1'b1; redirect_target = 32'h204;
    tick();
    redirect_valid = 1'b0;
    n_tests++; if (misalign_err !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL misalign_clear got merr=%b req=%b want merr=0 req=0", misalign_err, mem_req);
    end
    tick();
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h204) begin
      n_fail++; $display("FAIL misalign_resume got req=%b addr=%h want req=1 addr=00000204", mem_req, mem_addr);
    end
  endtask

  task automatic test_pc_wrap();
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    tick();
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_req got req=%b addr=%h want req=1 addr=fffffffc", mem_req, mem_addr);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    n_tests++; if (inst_pc !== 32'hFFFF_FFFC || mem_addr !== 32'h0) begin
      n_fail++; $display("FAIL wrap_pc got inst_pc=%h addr=%h want inst_pc=fffffffc addr=00000000", inst_pc, mem_addr);
    end
    tick();
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      n_fail++; $display("FAIL wrap_next got req=%b addr=%h want req=1 addr=00000000", mem_req, mem_addr);
    end
  endtask

  // Starts mid-REQ at address 0.
  task automatic test_async_reset();
    #2;
    n_rst = 1'b0;
    #1;
    check_reset_values("async_reset");
    en = 1'b0; mem_ack = 1'b1;
    tick();
    n_rst = 1'b1;
    tick();
    n_tests++; if (inst_valid !== 1'b0 || inst_pc !== 32'h0 || mem_req !== 1'b0 || mem_addr !== 32'h100) begin
      n_fail++; $display("FAIL post_reset_ack got v=%b pc=%h req=%b addr=%h want v=0 pc=0 req=0 addr=00000100", inst_valid, inst_pc, mem_req, mem_addr);
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cadence();
    test_stall();
    test_wait_and_timeout();
    test_redirect_with_ack();
    test_misalign();
    test_pc_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
